// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, controller state/class enums and mux encodings.
// ST_TRAP exists only when ILLEGAL_TRAP_EN is defined.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK
`ifdef ILLEGAL_TRAP_EN
        , ST_TRAP
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_NOP,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BR_JAL = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class; anything outside RV32I is CLS_ILLEGAL.
module opcode_classifier
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: op_class = CLS_ALU;
            OPC_LOAD:                               op_class = CLS_LOAD;
            OPC_STORE:                              op_class = CLS_STORE;
            OPC_BRANCH:                             op_class = CLS_BRANCH;
            OPC_JAL:                                op_class = CLS_JAL;
            OPC_JALR:                               op_class = CLS_JALR;
            OPC_FENCE, OPC_SYSTEM:                  op_class = CLS_NOP;
            default:                                op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: strobes decoded from state/class, 3-5 cycles per instruction plus waits.
// Stalls in FETCH/MEMORY until imem_ready/dmem_ready; ILLEGAL_TRAP_EN adds a sticky TRAP state.
module multicycle_controller
    import rv32i_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             trap,
    output logic [RET_W-1:0] retired
);

    state_e           state_q, state_d;
    op_class_e        cls_q, cls_d;
    op_class_e        dec_cls;
    logic [RET_W-1:0] retired_q, retired_d;

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (dec_cls)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        trap      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                cls_d   = dec_cls;
                state_d = (dec_cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
`else
                cls_d   = (dec_cls == CLS_ILLEGAL) ? CLS_NOP : dec_cls;
                state_d = ST_EXECUTE;
`endif
            end
            ST_EXECUTE: begin
                case (cls_q)
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_BR_JAL : PC_PLUS4;
                        state_d  = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE:       state_d = ST_MEMORY;
                    CLS_ALU, CLS_JAL, CLS_JALR: state_d = ST_WRITEBACK;
                    default: begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                endcase
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d  = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                reg_write = (rd != 5'd0);
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
                case (cls_q)
                    CLS_LOAD: wb_sel = WB_MEM;
                    CLS_JAL: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_BR_JAL;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_JALR;
                    end
                    default: ;
                endcase
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: trap = 1'b1;
`endif
            default: state_d = ST_FETCH;
        endcase

        // Every retire cycle is exactly a pc_write cycle.
        retired_d = pc_write ? retired_q + RET_W'(1) : retired_q;
        retired   = retired_q;

        // Reset masks the strobes combinationally so an in-flight request drops in the same cycle.
        if (reset) begin
            imem_req  = 1'b0;
            ir_write  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            reg_write = 1'b0;
            wb_sel    = WB_ALU;
            pc_write  = 1'b0;
            pc_src    = PC_PLUS4;
            trap      = 1'b0;
            retired   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NOP;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            retired_q <= retired_d;
        end
    end

endmodule
